// File: rtl/egress_tx.sv
// Egress transmitter: serializes a captured header once per destination port, lowest port first.
// Optional zero-bitmap drop counter output is enabled with `EGRESS_TX_DROP_CNT_EN.
`ifndef HDR_MAX_LEN
`define HDR_MAX_LEN 8
`endif
`ifndef NUM_PORTS
`define NUM_PORTS 4
`endif
`ifndef BYTE_BUS
`define BYTE_BUS 8
`endif
`ifndef TRUE
`define TRUE 1'b1
`endif

module egress_tx #(
  parameter int TX_LEN = `HDR_MAX_LEN
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   tm_valid_i,
  output logic                                   tm_ready_o,
  input  logic [`NUM_PORTS-1:0]                  tm_out_port_i,
  input  logic [`HDR_MAX_LEN-1:0][`BYTE_BUS-1:0] tm_pkt_hdr_i,
  output logic                                   tx_valid_o,
  input  logic                                   tx_ready_i,
  output logic [`BYTE_BUS-1:0]                   tx_data_o,
  output logic [`NUM_PORTS-1:0]                  tx_port_o,
  output logic                                   tx_sop_o,
`ifdef EGRESS_TX_DROP_CNT_EN
  output logic                                   tx_eop_o,
  output logic [31:0]                            drop_cnt_o
`else
  output logic                                   tx_eop_o
`endif
);

  localparam int NP     = `NUM_PORTS;
  localparam int IDX_W  = (TX_LEN > 1) ? $clog2(TX_LEN) : 1;
  localparam int PORT_W = (NP > 1) ? $clog2(NP) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                                 state_q, state_d;
  logic [`HDR_MAX_LEN-1:0][`BYTE_BUS-1:0] hdr_q;
  logic [NP-1:0]                          mask_q;
  logic [IDX_W-1:0]                       idx_q;
  logic [PORT_W-1:0]                      cur_q;
  logic [NP-1:0]                          port_oh;
  logic [NP-1:0]                          rem_mask;
  logic                                   last;
  logic                                   accept;
  logic                                   beat;

  function automatic logic [PORT_W-1:0] lowest(input logic [NP-1:0] m);
    lowest = '0;
    for (int i = NP - 1; i >= 0; i--)
      if (m[i]) lowest = PORT_W'(i);
  endfunction

  assign port_oh  = NP'(1) << cur_q;
  assign rem_mask = mask_q & ~port_oh;
  assign last     = (idx_q == IDX_W'(TX_LEN - 1));
  assign accept   = tm_valid_i & tm_ready_o;
  assign beat     = tx_valid_o & tx_ready_i;

  // Outputs decode purely from state and captured registers, never from tm_* inputs.
  always_comb begin
    state_d    = state_q;
    tm_ready_o = 1'b0;
    tx_valid_o = 1'b0;
    tx_data_o  = '0;
    tx_port_o  = '0;
    tx_sop_o   = 1'b0;
    tx_eop_o   = 1'b0;
    case (state_q)
      IDLE: begin
        tm_ready_o = (rst != `TRUE);
        if (tm_valid_i && (rst != `TRUE) && (tm_out_port_i != '0))
          state_d = SEND;
      end
      SEND: begin
        tx_valid_o = 1'b1;
        tx_data_o  = hdr_q[idx_q];
        tx_port_o  = port_oh;
        tx_sop_o   = (idx_q == '0);
        tx_eop_o   = last;
        if (tx_ready_i && last && (rem_mask == '0))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hdr_q   <= '0;
      mask_q  <= '0;
      idx_q   <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept && (tm_out_port_i != '0)) begin
        hdr_q  <= tm_pkt_hdr_i;
        mask_q <= tm_out_port_i;
        cur_q  <= lowest(tm_out_port_i);
        idx_q  <= '0;
      end else if (beat) begin
        // On the final byte of a copy, retire this port and hop straight to the next one.
        if (last) begin
          mask_q <= rem_mask;
          cur_q  <= lowest(rem_mask);
          idx_q  <= '0;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

`ifdef EGRESS_TX_DROP_CNT_EN
  logic [31:0] drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drop_q <= '0;
    else if (accept && (tm_out_port_i == '0) && (drop_q != 32'hFFFF_FFFF))
      drop_q <= drop_q + 32'd1;
  end

  assign drop_cnt_o = drop_q;
`endif

endmodule

// File: tb/tb_egress_tx.sv
// Directed self-checking bench for egress_tx with TX_LEN = 4 and 4 ports.
// Drop counter checks are included when `EGRESS_TX_DROP_CNT_EN is defined.
`ifndef HDR_MAX_LEN
`define HDR_MAX_LEN 8
`endif
`ifndef NUM_PORTS
`define NUM_PORTS 4
`endif
`ifndef BYTE_BUS
`define BYTE_BUS 8
`endif
`ifndef TRUE
`define TRUE 1'b1
`endif

module tb_egress_tx;

  logic                                   clk;
  logic                                   rst;
  logic                                   tm_valid_i;
  logic                                   tm_ready_o;
  logic [`NUM_PORTS-1:0]                  tm_out_port_i;
  logic [`HDR_MAX_LEN-1:0][`BYTE_BUS-1:0] tm_pkt_hdr_i;
  logic                                   tx_valid_o;
  logic                                   tx_ready_i;
  logic [`BYTE_BUS-1:0]                   tx_data_o;
  logic [`NUM_PORTS-1:0]                  tx_port_o;
  logic                                   tx_sop_o;
  logic                                   tx_eop_o;
`ifdef EGRESS_TX_DROP_CNT_EN
  logic [31:0]                            drop_cnt_o;
`endif

  int checks = 0;
  int passed = 0;

  egress_tx #(.TX_LEN(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .tm_valid_i    (tm_valid_i),
    .tm_ready_o    (tm_ready_o),
    .tm_out_port_i (tm_out_port_i),
    .tm_pkt_hdr_i  (tm_pkt_hdr_i),
    .tx_valid_o    (tx_valid_o),
    .tx_ready_i    (tx_ready_i),
    .tx_data_o     (tx_data_o),
    .tx_port_o     (tx_port_o),
    .tx_sop_o      (tx_sop_o),
`ifdef EGRESS_TX_DROP_CNT_EN
    .tx_eop_o      (tx_eop_o),
    .drop_cnt_o    (drop_cnt_o)
`else
    .tx_eop_o      (tx_eop_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic checkOutput(input string tag, input logic v, input logic [7:0] d,
                             input logic [3:0] p, input logic s, input logic e);
    chk({tag, ".valid"}, 32'(tx_valid_o), 32'(v));
    chk({tag, ".data"},  32'(tx_data_o),  32'(d));
    chk({tag, ".port"},  32'(tx_port_o),  32'(p));
    chk({tag, ".sop"},   32'(tx_sop_o),   32'(s));
    chk({tag, ".eop"},   32'(tx_eop_o),   32'(e));
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] map,
                               input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
    tm_valid_i    = v;
    tm_out_port_i = map;
    for (int i = 0; i < `HDR_MAX_LEN; i++) tm_pkt_hdr_i[i] = 8'hEE;
    tm_pkt_hdr_i[0] = b0;
    tm_pkt_hdr_i[1] = b1;
    tm_pkt_hdr_i[2] = b2;
    tm_pkt_hdr_i[3] = b3;
  endtask

  logic [7:0] bp_bytes [4];

  initial begin
    rst        = 1'b1;
    tx_ready_i = 1'b1;
    applyStimulus(1'b0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    step();
    checkOutput("reset", 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
    chk("reset.tm_ready", 32'(tm_ready_o), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_reset.tm_ready", 32'(tm_ready_o), 32'd1);

    // Unicast to port 2
    applyStimulus(1'b1, 4'b0100, 8'h11, 8'h22, 8'h33, 8'h44);
    step();
    tm_valid_i = 1'b0;
    chk("uni.tm_ready_busy", 32'(tm_ready_o), 32'd0);
    checkOutput("uni.b0", 1'b1, 8'h11, 4'b0100, 1'b1, 1'b0);
    step();
    checkOutput("uni.b1", 1'b1, 8'h22, 4'b0100, 1'b0, 1'b0);
    step();
    checkOutput("uni.b2", 1'b1, 8'h33, 4'b0100, 1'b0, 1'b0);
    step();
    checkOutput("uni.b3", 1'b1, 8'h44, 4'b0100, 1'b0, 1'b1);
    step();
    checkOutput("uni.idle", 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
    chk("uni.tm_ready_back", 32'(tm_ready_o), 32'd1);

    // Multicast to ports 1 and 3, with inputs scrambled during SEND
    applyStimulus(1'b1, 4'b1010, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    step();
    applyStimulus(1'b0, 4'b0101, 8'h5A, 8'h5B, 8'h5C, 8'h5D);
    checkOutput("mc.p1b0", 1'b1, 8'hA0, 4'b0010, 1'b1, 1'b0);
    step();
    checkOutput("mc.p1b1", 1'b1, 8'hA1, 4'b0010, 1'b0, 1'b0);
    step();
    checkOutput("mc.p1b2", 1'b1, 8'hA2, 4'b0010, 1'b0, 1'b0);
    step();
    checkOutput("mc.p1b3", 1'b1, 8'hA3, 4'b0010, 1'b0, 1'b1);
    step();
    checkOutput("mc.p3b0", 1'b1, 8'hA0, 4'b1000, 1'b1, 1'b0);
    step();
    checkOutput("mc.p3b1", 1'b1, 8'hA1, 4'b1000, 1'b0, 1'b0);
    step();
    checkOutput("mc.p3b2", 1'b1, 8'hA2, 4'b1000, 1'b0, 1'b0);
    step();
    checkOutput("mc.p3b3", 1'b1, 8'hA3, 4'b1000, 1'b0, 1'b1);
    step();
    checkOutput("mc.idle", 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);

    // Backpressure: ready pattern 1,0,0 repeating
    bp_bytes[0] = 8'hB0; bp_bytes[1] = 8'hB1; bp_bytes[2] = 8'hB2; bp_bytes[3] = 8'hB3;
    applyStimulus(1'b1, 4'b0001, 8'hB0, 8'hB1, 8'hB2, 8'hB3);
    tx_ready_i = 1'b0;
    step();
    tm_valid_i = 1'b0;
    begin
      int k = 0;
      int cyc = 0;
      while (k < 4 && cyc < 40) begin
        tx_ready_i = (cyc % 3 == 0);
        checkOutput("bp.beat", 1'b1, bp_bytes[k], 4'b0001, (k == 0), (k == 3));
        step();
        if (cyc % 3 == 0) k++;
        cyc++;
      end
      chk("bp.cycles", 32'(cyc), 32'd10);
    end
    tx_ready_i = 1'b1;
    checkOutput("bp.idle", 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);

    // Three back-to-back drops
    applyStimulus(1'b1, 4'b0000, 8'hD0, 8'hD1, 8'hD2, 8'hD3);
    for (int i = 0; i < 3; i++) begin
      chk("drop.tm_ready", 32'(tm_ready_o), 32'd1);
      step();
      chk("drop.tx_valid", 32'(tx_valid_o), 32'd0);
    end
    tm_valid_i = 1'b0;
`ifdef EGRESS_TX_DROP_CNT_EN
    chk("drop.count", drop_cnt_o, 32'd3);
`endif

    // Reset during the second byte of a two-port send
    applyStimulus(1'b1, 4'b0011, 8'hC0, 8'hC1, 8'hC2, 8'hC3);
    step();
    tm_valid_i = 1'b0;
    step();
    checkOutput("rstmid.b1", 1'b1, 8'hC1, 4'b0001, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("rstmid.async", 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
    chk("rstmid.tm_ready", 32'(tm_ready_o), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rstmid.ready_after", 32'(tm_ready_o), 32'd1);
    applyStimulus(1'b1, 4'b1000, 8'hE0, 8'hE1, 8'hE2, 8'hE3);
    step();
    tm_valid_i = 1'b0;
    checkOutput("post.b0", 1'b1, 8'hE0, 4'b1000, 1'b1, 1'b0);
    step();
    checkOutput("post.b1", 1'b1, 8'hE1, 4'b1000, 1'b0, 1'b0);
    step();
    checkOutput("post.b2", 1'b1, 8'hE2, 4'b1000, 1'b0, 1'b0);
    step();
    checkOutput("post.b3", 1'b1, 8'hE3, 4'b1000, 1'b0, 1'b1);
    step();
    checkOutput("post.idle", 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
`ifdef EGRESS_TX_DROP_CNT_EN
    chk("post.drop_count", drop_cnt_o, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
